// File: rtl/demod_16qam_iq.sv
// Coherent 16QAM demodulator.
// Mixes the passband input with the shared carrier (I = cos, Q = sin), integrates and dumps over one
// symbol of SPS carrier samples, then slices each axis to one of four levels.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   sample_valid        carrier clock-enable, one sample present this cycle
//   mod_in              signed 9-bit passband sample
//   carrier_sin/cos     signed 8-bit carrier samples, phase-aligned with mod_in
//   sym_sync            first sample of a symbol (qualified by sample_valid)
//   code, code_valid    recovered symbol {I1,Q1,I0,Q0} and its one-cycle strobe
//   locked              high while integrating in symbol alignment
//   sync_err            one-cycle strobe, sym_sync arrived mid-symbol
module demod_16qam_iq #(
  parameter int unsigned SPS   = 16,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned UNIT  = 31752
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic signed [8:0] mod_in,
  input  logic signed [7:0] carrier_sin,
  input  logic signed [7:0] carrier_cos,
  input  logic              sym_sync,
  output logic [3:0]        code,
  output logic              code_valid,
  output logic              locked,
  output logic              sync_err
);

  localparam int unsigned CntW = $clog2(SPS);

  localparam logic [0:0] StWaitSync = 1'b0;
  localparam logic [0:0] StInteg    = 1'b1;

  // Slicer thresholds on d = 2*dump; levels sit at 2*UNIT spacing, thresholds halfway between.
  localparam logic signed [ACC_W:0] ThrP1 = (ACC_W + 1)'(UNIT);
  localparam logic signed [ACC_W:0] ThrN1 = -ThrP1;
  localparam logic signed [ACC_W:0] ThrP3 = (ACC_W + 1)'(3 * UNIT);
  localparam logic signed [ACC_W:0] ThrN3 = -ThrP3;

  logic [0:0] state_q, state_d;
  logic       take;

  // Stage 1: products
  logic signed [16:0] p_i_q, p_q_q;
  logic               prod_v_q, prod_sync_q;

  // Stage 2: integrate-and-dump
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [ACC_W-1:0] sum_i, sum_q;
  logic signed [ACC_W-1:0] dump_i_q, dump_i_d, dump_q_q, dump_q_d;
  logic [CntW-1:0]         cnt_q, cnt_d, base_cnt;
  logic                    dump_v_q, dump_v_d;
  logic                    sync_err_q, sync_err_d;

  // Stage 3: slicer
  logic [3:0] code_q, code_d;
  logic       code_valid_q;
  logic [1:0] bits_i, bits_q;

  function automatic logic [1:0] slice(input logic signed [ACC_W:0] d);
    logic [1:0] b;
    if (d < ThrN3)      b = 2'b10;
    else if (d < ThrN1) b = 2'b11;
    else if (d < ThrP1) b = 2'b00;
    else                b = 2'b01;
    return b;
  endfunction

  // Before lock only a sync-marked sample gets into the pipeline.
  assign take = sample_valid & ((state_q == StInteg) | sym_sync);

  always_comb begin
    state_d = state_q;
    if (sample_valid && sym_sync) state_d = StInteg;
  end

  always_comb begin
    // A sync-marked product restarts the symbol regardless of where the counter was.
    base_cnt   = prod_sync_q ? '0 : cnt_q;
    sum_i      = (prod_sync_q ? '0 : acc_i_q) + ACC_W'(p_i_q);
    sum_q      = (prod_sync_q ? '0 : acc_q_q) + ACC_W'(p_q_q);
    acc_i_d    = acc_i_q;
    acc_q_d    = acc_q_q;
    cnt_d      = cnt_q;
    dump_i_d   = dump_i_q;
    dump_q_d   = dump_q_q;
    dump_v_d   = 1'b0;
    sync_err_d = 1'b0;
    if (prod_v_q) begin
      sync_err_d = prod_sync_q && (cnt_q != '0);
      if (base_cnt == CntW'(SPS - 1)) begin
        dump_i_d = sum_i;
        dump_q_d = sum_q;
        dump_v_d = 1'b1;
        acc_i_d  = '0;
        acc_q_d  = '0;
        cnt_d    = '0;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        cnt_d   = base_cnt + CntW'(1);
      end
    end
  end

  always_comb begin
    bits_i = slice({dump_i_q, 1'b0});
    bits_q = slice({dump_q_q, 1'b0});
    code_d = code_q;
    if (dump_v_q) code_d = {bits_i[1], bits_q[1], bits_i[0], bits_q[0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StWaitSync;
      p_i_q        <= '0;
      p_q_q        <= '0;
      prod_v_q     <= 1'b0;
      prod_sync_q  <= 1'b0;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      cnt_q        <= '0;
      dump_i_q     <= '0;
      dump_q_q     <= '0;
      dump_v_q     <= 1'b0;
      sync_err_q   <= 1'b0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prod_v_q    <= take;
      prod_sync_q <= take & sym_sync;
      if (take) begin
        p_i_q <= mod_in * carrier_cos;
        p_q_q <= mod_in * carrier_sin;
      end
      acc_i_q      <= acc_i_d;
      acc_q_q      <= acc_q_d;
      cnt_q        <= cnt_d;
      dump_i_q     <= dump_i_d;
      dump_q_q     <= dump_q_d;
      dump_v_q     <= dump_v_d;
      sync_err_q   <= sync_err_d;
      code_q       <= code_d;
      code_valid_q <= dump_v_q;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign locked     = (state_q == StInteg);
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_demod_16qam_iq.sv
// Self-checking bench for demod_16qam_iq: randomized modulated/raw stimulus against a
// sample-level reference model (exact correlation sums, level = floor((2*sum + UNIT) / (2*UNIT))).
module tb_demod_16qam_iq;

  localparam int SPS   = 16;
  localparam int ACC_W = 24;
  localparam int UNIT  = 31752;

  logic              clk = 1'b0;
  logic              reset;
  logic              sample_valid;
  logic signed [8:0] mod_in;
  logic signed [7:0] carrier_sin;
  logic signed [7:0] carrier_cos;
  logic              sym_sync;
  logic [3:0]        code;
  logic              code_valid;
  logic              locked;
  logic              sync_err;

  demod_16qam_iq #(
    .SPS  (SPS),
    .ACC_W(ACC_W),
    .UNIT (UNIT)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .mod_in      (mod_in),
    .carrier_sin (carrier_sin),
    .carrier_cos (carrier_cos),
    .sym_sync    (sym_sync),
    .code        (code),
    .code_valid  (code_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cos_t[SPS];
  int sin_t[SPS];
  int ph = 0;

  // Reference model state
  bit         locked_m = 1'b0;
  int         cnt_m = 0;
  longint     sum_i = 0;
  longint     sum_q = 0;
  logic [3:0] code_m = 4'd0;
  logic [3:0] exp_code_q[$];
  int         due_q[$];
  int         serr_q[$];
  logic [3:0] got_q[$];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int level_of(input longint d);
    longint num, den, q;
    num = d + UNIT;
    den = 2 * UNIT;
    q = num / den;
    if (num < 0 && q * den != num) q--;
    if (q > 1) q = 1;
    if (q < -2) q = -2;
    return int'(q);
  endfunction

  function automatic logic [3:0] code_of(input longint si, input longint sq);
    logic [1:0] bi, bq;
    bi = 2'(level_of(2 * si));
    bq = 2'(level_of(2 * sq));
    return {bi[1], bq[1], bi[0], bq[0]};
  endfunction

  function automatic int lvl(input logic [1:0] b);
    return b[1] ? int'(b) - 4 : int'(b);
  endfunction

  task automatic step(input bit rst, input bit v, input bit sy, input int m, input int s,
                      input int c);
    bit exp_v, exp_e;
    reset = rst;
    sample_valid = v;
    sym_sync = sy;
    mod_in = 9'(m);
    carrier_sin = 8'(s);
    carrier_cos = 8'(c);
    @(posedge clk);
    cyc++;
    if (rst) begin
      locked_m = 1'b0;
      cnt_m = 0;
      sum_i = 0;
      sum_q = 0;
      code_m = 4'd0;
      exp_code_q.delete();
      due_q.delete();
      serr_q.delete();
    end else if (v && (locked_m || sy)) begin
      if (sy) begin
        if (locked_m && cnt_m != 0) serr_q.push_back(cyc + 1);
        sum_i = 0;
        sum_q = 0;
        cnt_m = 0;
        locked_m = 1'b1;
      end
      sum_i += longint'(m * c);
      sum_q += longint'(m * s);
      cnt_m++;
      if (cnt_m == SPS) begin
        exp_code_q.push_back(code_of(sum_i, sum_q));
        due_q.push_back(cyc + 2);
        sum_i = 0;
        sum_q = 0;
        cnt_m = 0;
      end
    end
    #1;
    exp_v = (due_q.size() > 0 && due_q[0] == cyc);
    if (exp_v) begin
      void'(due_q.pop_front());
      code_m = exp_code_q.pop_front();
    end
    exp_e = (serr_q.size() > 0 && serr_q[0] == cyc);
    if (exp_e) void'(serr_q.pop_front());
    check_eq("code_valid", code_valid, exp_v);
    check_eq("code", code, code_m);
    check_eq("sync_err", sync_err, exp_e);
    check_eq("locked", locked, locked_m);
    if (code_valid) got_q.push_back(code);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  // One carrier sample of a modulated symbol; invalid cycles carry junk that must be ignored.
  task automatic mod_sample(input bit v, input bit sy, input logic [3:0] cd, input int noise);
    int m;
    if (!v) begin
      step(1'b0, 1'b0, sy, $urandom_range(511) - 256, $urandom_range(255) - 128,
           $urandom_range(255) - 128);
    end else begin
      if (sy) ph = 0;
      m = lvl({cd[3], cd[1]}) * cos_t[ph] + lvl({cd[2], cd[0]}) * sin_t[ph] + noise;
      step(1'b0, 1'b1, sy, m, sin_t[ph], cos_t[ph]);
      ph = (ph + 1) % SPS;
    end
  endtask

  task automatic send_symbol(input logic [3:0] cd, input int gap_pct, input int noise_amp);
    int nz;
    for (int n = 0; n < SPS; n++) begin
      while ($urandom_range(99) < gap_pct) mod_sample(1'b0, 1'b0, cd, 0);
      nz = (noise_amp > 0) ? $urandom_range(2 * noise_amp) - noise_amp : 0;
      mod_sample(1'b1, n == 0, cd, nz);
    end
  endtask

  // Symbol whose I correlation is n_big * big_m * 126, optionally minus one.
  task automatic edge_symbol(input int n_big, input int big_m, input bit minus_one);
    int m, c;
    for (int n = 0; n < SPS; n++) begin
      m = 0;
      c = 0;
      if (n < n_big) begin
        m = big_m;
        c = 126;
      end else if (n == n_big && minus_one) begin
        m = -1;
        c = 1;
      end
      step(1'b0, 1'b1, n == 0, m, 0, c);
    end
  endtask

  initial begin
    int base;
    logic [3:0] cd;
    for (int n = 0; n < SPS; n++) begin
      cos_t[n] = int'(63.0 * $cos(2.0 * 3.14159265358979 * n / SPS));
      sin_t[n] = int'(63.0 * $sin(2.0 * 3.14159265358979 * n / SPS));
    end

    // Reset, then valid samples with no sync must be ignored.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < SPS; i++) mod_sample(1'b1, 1'b0, 4'd7, 0);
    idle(3);
    check_eq("nosync_codes", got_q.size(), 0);

    // Loopback 0..15 twice, back-to-back.
    base = got_q.size();
    for (int i = 0; i < 32; i++) send_symbol(4'(i % 16), 0, 0);
    idle(3);
    check_eq("loop_count", got_q.size() - base, 32);
    if (got_q.size() >= base + 32)
      for (int i = 0; i < 32; i++) check_eq("loop_code", got_q[base + i], i % 16);

    // Constant I=+1, Q=-2.
    base = got_q.size();
    for (int i = 0; i < 4; i++) send_symbol(4'b0110, 20, 0);
    idle(3);
    check_eq("const_count", got_q.size() - base, 4);
    for (int i = base; i < got_q.size(); i++) check_eq("const_code", got_q[i], 4'b0110);

    // Slicer thresholds: d = UNIT, UNIT-2, -3*UNIT, -3*UNIT-2 on I, Q = 0.
    edge_symbol(1, 126, 1'b0);
    idle(3);
    check_eq("thr_p1", got_q[$], 4'b0010);
    edge_symbol(1, 126, 1'b1);
    idle(3);
    check_eq("thr_p1_m2", got_q[$], 4'b0000);
    edge_symbol(3, -126, 1'b0);
    idle(3);
    check_eq("thr_n3", got_q[$], 4'b1010);
    edge_symbol(3, -126, 1'b1);
    idle(3);
    check_eq("thr_n3_m2", got_q[$], 4'b1000);

    // Sync at cnt=5: partial symbol dropped, next code 16 samples after the new sync.
    base = got_q.size();
    for (int n = 0; n < 5; n++) mod_sample(1'b1, n == 0, 4'b0011, 0);
    send_symbol(4'b1001, 0, 0);
    idle(3);
    check_eq("inject_count", got_q.size() - base, 1);
    check_eq("inject_code", got_q[$], 4'b1001);

    // Randomized modulated symbols with gaps and noise.
    for (int i = 0; i < 40; i++) send_symbol(4'($urandom_range(15)), 30, 6);
    // Raw random samples exercise arbitrary slicer inputs.
    for (int i = 0; i < 10 * SPS; i++)
      step(1'b0, 1'b1, (i % SPS) == 0, $urandom_range(511) - 256, $urandom_range(255) - 128,
           $urandom_range(255) - 128);
    idle(3);

    // Toggling valid, reset at cnt=9, then relock only on the next sync.
    for (int n = 0; n < 9; n++) begin
      mod_sample(1'b1, n == 0, 4'b1111, 0);
      mod_sample(1'b0, 1'b0, 4'b1111, 0);
    end
    step(1'b1, 1'b1, 1'b0, 5, 5, 5);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_code", code, 0);
    base = got_q.size();
    for (int n = 0; n < 10; n++) mod_sample(1'b1, 1'b0, 4'b0101, 0);
    check_eq("rst_relock", locked, 0);
    for (int i = 0; i < 3; i++) begin
      cd = 4'($urandom_range(15));
      send_symbol(cd, 50, 0);
      idle(3);
      check_eq("relock_code", got_q[$], cd);
    end
    check_eq("relock_count", got_q.size() - base, 3);

    idle(4);
    check_eq("pending_codes", due_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
